// File: rtl/regfile_dest_tracker_pkg.sv
// regfile_dest_tracker_pkg: shared defaults, entry layout and bypass-select encoding for the decode dest tracker
package regfile_dest_tracker_pkg;
  localparam int IDX_BITS_DEF = 5;
  localparam int LINK_REG_DEF = 31;
  localparam int STAGES_DEF = 3;
  localparam int RF_WT_DEF = 1;
  localparam int FWD_RF = 0;
  typedef struct packed {
    logic v;
    logic [IDX_BITS_DEF-1:0] idx;
    logic load;
  } entry_t;
  function automatic int fwd_bits(input int stages);
    return $clog2(stages + 1);
  endfunction
endpackage

// File: rtl/regfile_dest_match.sv
// regfile_dest_match: compares one source index against all in-flight entries, returns hit and youngest-hit select (k+1)
module regfile_dest_match
  import regfile_dest_tracker_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int RF_WRITE_THROUGH = RF_WT_DEF,
  localparam int FB = fwd_bits(STAGES)
) (
  input  logic [IDX_BITS-1:0]             i_src,
  input  logic                            i_use,
  input  logic [STAGES-1:0]               i_v,
  input  logic [STAGES-1:0][IDX_BITS-1:0] i_idx,
  output logic                            o_hit,
  output logic [FB-1:0]                   o_sel
);
  localparam int LIM = RF_WRITE_THROUGH != 0 ? STAGES - 1 : STAGES;
  // scan oldest to youngest so the youngest match overwrites
  always_comb begin
    o_sel = FB'(FWD_RF);
    for (int k = STAGES - 1; k >= 0; k--)
      if (k < LIM && i_use && i_src != '0 && i_v[k] && i_idx[k] == i_src) o_sel = FB'(k + 1);
  end
  assign o_hit = o_sel != FB'(FWD_RF);
endmodule

// File: rtl/regfile_dest_tracker.sv
// regfile_dest_tracker: decode-stage read/write index select, in-flight dest tracking, RAW stall and bypass select.
// Build option: REGFILE_FORWARD_EN enables bypass selects and reduces stalls to load-use only.
module regfile_dest_tracker
  import regfile_dest_tracker_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF,
  parameter int LINK_REG = LINK_REG_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int RF_WRITE_THROUGH = RF_WT_DEF,
  localparam int FB = fwd_bits(STAGES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] i_rs,
  input  logic [IDX_BITS-1:0] i_rt,
  input  logic [IDX_BITS-1:0] i_rd,
  input  logic                i_use_rs,
  input  logic                i_use_rt,
  input  logic                i_jal,
  input  logic                i_reg_dst,
  input  logic                i_reg_write,
  input  logic                i_mem_to_reg,
  input  logic                i_in_valid,
  input  logic                i_en,
  input  logic                i_flush,
  output logic [IDX_BITS-1:0] o_ir1,
  output logic [IDX_BITS-1:0] o_ir2,
  output logic [IDX_BITS-1:0] o_w,
  output logic                o_stall,
  output logic [FB-1:0]       o_fwd_rs,
  output logic [FB-1:0]       o_fwd_rt
);
  logic [STAGES-1:0]               r_v;
  logic [STAGES-1:0][IDX_BITS-1:0] r_idx;
  logic                            r_ld0;
  logic                            w_wr_d, w_bubble, w_stall, w_load_use;
  logic                            w_hit_rs, w_hit_rt;
  logic [FB-1:0]                   w_sel_rs, w_sel_rt, w_fwd_rs, w_fwd_rt;
  assign o_ir1 = i_rs;
  assign o_ir2 = i_rt;
  assign o_w = i_jal ? IDX_BITS'(LINK_REG) : i_reg_dst ? i_rd : i_rt;
  assign w_wr_d = i_in_valid & (i_reg_write | i_jal) & (o_w != '0);
  assign w_bubble = w_stall | i_flush;
  regfile_dest_match #(.IDX_BITS(IDX_BITS), .STAGES(STAGES), .RF_WRITE_THROUGH(RF_WRITE_THROUGH)) u_match_rs (
    .i_src(i_rs), .i_use(i_use_rs), .i_v(r_v), .i_idx(r_idx), .o_hit(w_hit_rs), .o_sel(w_sel_rs)
  );
  regfile_dest_match #(.IDX_BITS(IDX_BITS), .STAGES(STAGES), .RF_WRITE_THROUGH(RF_WRITE_THROUGH)) u_match_rt (
    .i_src(i_rt), .i_use(i_use_rt), .i_v(r_v), .i_idx(r_idx), .o_hit(w_hit_rt), .o_sel(w_sel_rt)
  );
  // only the youngest entry's load bit can ever cause a load-use bubble
  assign w_load_use = r_ld0 & ((w_sel_rs == FB'(1)) | (w_sel_rt == FB'(1)));
`ifdef REGFILE_FORWARD_EN
  assign w_stall = w_load_use;
  assign w_fwd_rs = w_hit_rs ? w_sel_rs : FB'(FWD_RF);
  assign w_fwd_rt = w_hit_rt ? w_sel_rt : FB'(FWD_RF);
`else
  assign w_stall = w_load_use | w_hit_rs | w_hit_rt;
  assign w_fwd_rs = FB'(FWD_RF);
  assign w_fwd_rt = FB'(FWD_RF);
`endif
  assign o_stall = ~rst & w_stall;
  assign o_fwd_rs = rst ? FB'(FWD_RF) : w_fwd_rs;
  assign o_fwd_rt = rst ? FB'(FWD_RF) : w_fwd_rt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      r_ld0 <= 1'b0;
    end else if (i_en) begin
      for (int i = STAGES - 1; i > 0; i--) r_v[i] <= r_v[i-1];
      r_v[0] <= ~w_bubble & w_wr_d;
      r_ld0 <= ~w_bubble & w_wr_d & i_mem_to_reg & ~i_jal;
    end
  end
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = STAGES - 1; i > 0; i--) r_idx[i] <= r_idx[i-1];
      r_idx[0] <= o_w;
    end
  end
endmodule

// File: tb/tb_regfile_dest_tracker.sv
// tb_regfile_dest_tracker: directed + randomized stimulus against a queue-based reference model of the tracker
module tb_regfile_dest_tracker;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs, rt, rd;
  logic use_rs, use_rt, jal, reg_dst, reg_write, mem_to_reg, in_valid, en, flush;
  logic [4:0] ir1, ir2, w;
  logic stall;
  logic [1:0] fwd_rs, fwd_rt;
  int errors = 0;
  int checks = 0;
  typedef struct {bit v; int idx; bit ld;} ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  regfile_dest_tracker dut (
    .clk(clk), .rst(rst), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_use_rs(use_rs), .i_use_rt(use_rt),
    .i_jal(jal), .i_reg_dst(reg_dst), .i_reg_write(reg_write), .i_mem_to_reg(mem_to_reg),
    .i_in_valid(in_valid), .i_en(en), .i_flush(flush), .o_ir1(ir1), .o_ir2(ir2), .o_w(w),
    .o_stall(stall), .o_fwd_rs(fwd_rs), .o_fwd_rt(fwd_rt)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // youngest in-flight writer of s; oldest slot is excluded because the RegFile writes through
  function automatic int youngest(input int s, input bit u);
    for (int k = 0; k < 2; k++)
      if (u && s != 0 && q[k].v && q[k].idx == s) return k;
    return -1;
  endfunction

  function automatic int exp_w();
    return jal ? 31 : (reg_dst ? int'(rd) : int'(rt));
  endfunction

  function automatic bit exp_stall_raw();
    int ks = youngest(rs, use_rs);
    int kt = youngest(rt, use_rt);
`ifdef REGFILE_FORWARD_EN
    return (ks == 0 && q[0].ld) || (kt == 0 && q[0].ld);
`else
    return ks >= 0 || kt >= 0;
`endif
  endfunction

  function automatic int exp_fwd(input int s, input bit u);
`ifdef REGFILE_FORWARD_EN
    return rst ? 0 : youngest(s, u) + 1;
`else
    return 0;
`endif
  endfunction

  task automatic cyc();
    bit st;
    int wv;
    ent_t e;
    #1;
    st = exp_stall_raw();
    wv = exp_w();
    check("ir1", ir1, rs);
    check("ir2", ir2, rt);
    check("w", w, wv);
    check("stall", stall, rst ? 0 : st);
    check("fwd_rs", fwd_rs, exp_fwd(rs, use_rs));
    check("fwd_rt", fwd_rt, exp_fwd(rt, use_rt));
    @(posedge clk);
    if (rst) begin
      foreach (q[i]) q[i] = '{0, 0, 0};
    end else if (en) begin
      e.v = !(st || flush) && in_valid && (reg_write || jal) && wv != 0;
      e.idx = wv;
      e.ld = e.v && mem_to_reg && !jal;
      void'(q.pop_back());
      q.push_front(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    {use_rs, use_rt, jal, reg_dst, reg_write, mem_to_reg, in_valid, flush} = '0;
    en = 1'b1;
    rs = 0; rt = 0; rd = 0;
  endtask

  task automatic instr(input int d, input int s, input int t, input bit ld);
    idle();
    in_valid = 1; reg_write = 1; reg_dst = 1; use_rs = 1; use_rt = 1; mem_to_reg = ld;
    rd = d[4:0]; rs = s[4:0]; rt = t[4:0];
  endtask

  function automatic logic [4:0] ridx();
    return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) q.push_back('{0, 0, 0});
    idle();
    rst = 1; reg_write = 1; in_valid = 1; rd = 8; reg_dst = 1; use_rs = 1; rs = 8;
    @(negedge clk);
    cyc(); cyc();
    rst = 0;
    idle(); use_rs = 1; rs = 8;
    cyc();
    // write index select
    idle(); rd = 5; rt = 6; jal = 1; #1 check("w_jal", w, 31);
    jal = 0; reg_dst = 1; #1 check("w_rd", w, 5);
    reg_dst = 0; #1 check("w_rt", w, 6);
    // $0 destination is never tracked
    instr(0, 1, 2, 0); cyc();
    instr(3, 0, 0, 0); #1 check("w0_nostall", stall, 0); cyc();
    idle(); cyc(); cyc(); cyc();
    // ALU RAW
    instr(8, 1, 2, 0); cyc();
    instr(9, 8, 8, 0); cyc(); cyc(); cyc();
    idle(); cyc(); cyc();
    // load-use
    instr(8, 1, 2, 1); cyc();
    instr(9, 8, 3, 0); cyc(); cyc(); cyc();
    idle(); cyc(); cyc();
    // youngest priority and flush of producer
    instr(8, 1, 2, 0); cyc();
    instr(8, 3, 4, 0); cyc();
    instr(10, 8, 0, 0); cyc();
    instr(8, 1, 2, 0); flush = 1; cyc();
    instr(11, 8, 8, 0); cyc();
    idle(); cyc(); cyc(); cyc();
    // freeze, then stall with flush
    instr(8, 1, 2, 1); cyc();
    instr(9, 8, 8, 0); en = 0; cyc(); cyc(); cyc();
    en = 1; flush = 1; cyc();
    flush = 0; cyc(); cyc(); cyc();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rs = ridx(); rt = ridx(); rd = ridx();
      use_rs = $urandom_range(0, 3) != 0;
      use_rt = $urandom_range(0, 1) != 0;
      jal = $urandom_range(0, 9) == 0;
      reg_dst = $urandom_range(0, 1) != 0;
      reg_write = $urandom_range(0, 3) != 0;
      mem_to_reg = $urandom_range(0, 2) == 0;
      in_valid = $urandom_range(0, 7) != 0;
      en = $urandom_range(0, 4) != 0;
      flush = $urandom_range(0, 9) == 0;
      rst = $urandom_range(0, 99) == 0;
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
